// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types for the memory-access pipeline stage:
//   - datapath widths (XLEN, ADDRW, MASKW, REGW)
//   - mem_size_e   : access size (byte / half / word)
//   - mem_state_e  : memory-stage FSM states
//   - ex_mem_t     : execute -> memory pipeline record
//   - mem_wb_t     : memory -> writeback pipeline record (with debug trace)
//   - lane_mask()  : byte-enable mask for a given size and byte lane
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int XLEN  = 32;
    localparam int ADDRW = 32;
    localparam int MASKW = XLEN / 8;
    localparam int REGW  = 5;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [REGW-1:0] rs1_s;
        logic [REGW-1:0] rs2_s;
    } ex_dbg_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] rs2_v;
        logic [REGW-1:0] rd_s;
        logic            rd_we;
        logic            is_load;
        logic            is_store;
        mem_size_e       size;
        logic            unsigned_ld;
        ex_dbg_t         debug;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [31:0]      instr;
        logic [REGW-1:0]  rs1_s;
        logic [REGW-1:0]  rs2_s;
        logic [XLEN-1:0]  mem_addr;
        logic [MASKW-1:0] rmask;
        logic [MASKW-1:0] wmask;
        logic [XLEN-1:0]  wdata;
        logic [XLEN-1:0]  rdata;
        logic             misalign;
    } mem_dbg_t;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rd_s;
        logic            rd_we;
        logic [XLEN-1:0] rd_v;
        mem_dbg_t        debug;
    } mem_wb_t;

    // Mask is built twice as wide so a shifted half at lane 3 simply drops
    // its upper bit instead of wrapping around.
    function automatic logic [MASKW-1:0] lane_mask(input mem_size_e size,
                                                   input logic [1:0] lane);
        logic [2*MASKW-1:0] m;
        case (size)
            MEM_B:   m = (2*MASKW)'(1) << lane;
            MEM_H:   m = (2*MASKW)'(3) << lane;
            default: m = (2*MASKW)'({MASKW{1'b1}});
        endcase
        return m[MASKW-1:0];
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data alignment: shifts the addressed byte lane down to
// bit 0, then zero- or sign-extends according to access size.
// Ports:
//   i_rdata    : raw word returned by data memory
//   i_lane     : byte offset within the word (alu_res[1:0])
//   i_size     : access size (mem_size_e)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_rd_v     : aligned, extended result for the register file
// ---------------------------------------------------------------------------
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_lane,
    input  mem_size_e       i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_rd_v
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign_b;
    logic            w_sign_h;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};
    assign w_sign_b  = ~i_unsigned & w_shifted[7];
    assign w_sign_h  = ~i_unsigned & w_shifted[15];

    always_comb begin
        o_rd_v = w_shifted;
        case (i_size)
            MEM_B:   o_rd_v = {{(XLEN-8){w_sign_b}},  w_shifted[7:0]};
            MEM_H:   o_rd_v = {{(XLEN-16){w_sign_h}}, w_shifted[15:0]};
            default: o_rd_v = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between execute and writeback. Issues loads
// and stores on a request/grant/response data-memory port, aligns load data,
// builds store byte masks and registers the mem_wb_t record. Upstream is
// stalled (and must hold ex_mem_i stable) while an access is outstanding.
//
// Parameter:
//   RSP_TIMEOUT : cycles in WAIT_RSP before a load is abandoned (0 = never)
// Optional build macro:
//   MEM_MISALIGN_CHECK_EN : misaligned half/word accesses are not issued;
//                           they complete with rd_we=0 and debug.misalign=1.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   ex_mem_i         : execute/memory record
//   stall_o          : hold ex_mem_i upstream
//   dmem_req_o/we_o/addr_o/wmask_o/wdata_o : memory request
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i : memory grant / response
//   mem_wb_o         : registered writeback record
//   timeout_o        : one-cycle pulse, aligned with the abandoned load's
//                      completion record
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  ex_mem_t          ex_mem_i,
    output logic             stall_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [ADDRW-1:0] dmem_addr_o,
    output logic [MASKW-1:0] dmem_wmask_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output mem_wb_t          mem_wb_o,
    output logic             timeout_o
);

    localparam int CW = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;

    mem_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    mem_wb_t         r_mem_wb;
    logic            r_timeout;

    mem_state_e       w_state_next;
    mem_wb_t          w_wb_next;
    logic [1:0]       w_lane;
    logic             w_is_mem;
    logic             w_misalign;
    logic             w_access;
    logic             w_issue;
    logic [MASKW-1:0] w_mask;
    logic [XLEN-1:0]  w_st_data;
    logic [XLEN-1:0]  w_ld_v;
    logic             w_to_hit;
    logic             w_complete;
    logic             w_load_done;
    logic             w_rd_we;
    logic             w_timeout;
    logic             w_stall;

    assign w_lane   = ex_mem_i.alu_res[1:0];
    assign w_is_mem = ex_mem_i.valid & (ex_mem_i.is_load | ex_mem_i.is_store);

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (w_is_mem) begin
            case (ex_mem_i.size)
                MEM_H:   w_misalign = w_lane[0];
                MEM_W:   w_misalign = (w_lane != 2'b00);
                default: w_misalign = 1'b0;
            endcase
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_access = w_is_mem & ~w_misalign;
    assign w_issue  = w_access & ((r_state == ST_IDLE) | (r_state == ST_REQ));
    assign w_mask   = lane_mask(ex_mem_i.size, w_lane);

    always_comb begin
        case (ex_mem_i.size)
            MEM_B:   w_st_data = {MASKW{ex_mem_i.rs2_v[7:0]}};
            MEM_H:   w_st_data = {(MASKW/2){ex_mem_i.rs2_v[15:0]}};
            default: w_st_data = ex_mem_i.rs2_v;
        endcase
    end

    // Request outputs are combinational from the held ex_mem_i record, so
    // they stay stable across REQ cycles while upstream is stalled.
    assign dmem_req_o   = w_issue;
    assign dmem_we_o    = w_issue & ex_mem_i.is_store;
    assign dmem_addr_o  = {ex_mem_i.alu_res[ADDRW-1:2], 2'b00};
    assign dmem_wmask_o = (w_issue & ex_mem_i.is_store) ? w_mask : '0;
    assign dmem_wdata_o = (w_issue & ex_mem_i.is_store) ? w_st_data : '0;

    load_align u_load_align (
        .i_rdata    (dmem_rdata_i),
        .i_lane     (w_lane),
        .i_size     (ex_mem_i.size),
        .i_unsigned (ex_mem_i.unsigned_ld),
        .o_rd_v     (w_ld_v)
    );

    generate
        if (RSP_TIMEOUT != 0) begin : g_timeout
            localparam logic [CW-1:0] TO_LAST = CW'(RSP_TIMEOUT - 1);
            assign w_to_hit = (r_cnt == TO_LAST);
        end else begin : g_no_timeout
            assign w_to_hit = 1'b0;
        end
    endgenerate

    // Next-state and completion decode.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_load_done  = 1'b0;
        w_rd_we      = 1'b0;
        w_timeout    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE, ST_REQ: begin
                w_state_next = ST_IDLE;
                if (ex_mem_i.valid) begin
                    if (!w_access) begin
                        // ALU op, or a rejected misaligned access
                        w_complete = 1'b1;
                        w_rd_we    = ex_mem_i.rd_we & ~w_is_mem;
                    end else if (!dmem_gnt_i) begin
                        w_stall      = 1'b1;
                        w_state_next = ST_REQ;
                    end else if (ex_mem_i.is_store) begin
                        w_complete = 1'b1;
                    end else if (dmem_rvalid_i) begin
                        w_complete  = 1'b1;
                        w_load_done = 1'b1;
                        w_rd_we     = ex_mem_i.rd_we;
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // rvalid is tested first so it wins over a same-cycle timeout
                if (dmem_rvalid_i) begin
                    w_complete   = 1'b1;
                    w_load_done  = 1'b1;
                    w_rd_we      = ex_mem_i.rd_we;
                    w_state_next = ST_IDLE;
                end else if (w_to_hit) begin
                    w_complete   = 1'b1;
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign stall_o = w_stall;

    always_comb begin
        w_wb_next = '0;
        if (w_complete) begin
            w_wb_next.valid          = 1'b1;
            w_wb_next.rd_s           = ex_mem_i.rd_s;
            w_wb_next.rd_we          = w_rd_we;
            w_wb_next.rd_v           = w_load_done ? w_ld_v
                                     : (w_is_mem ? '0 : ex_mem_i.alu_res);
            w_wb_next.debug.pc       = ex_mem_i.debug.pc;
            w_wb_next.debug.instr    = ex_mem_i.debug.instr;
            w_wb_next.debug.rs1_s    = ex_mem_i.debug.rs1_s;
            w_wb_next.debug.rs2_s    = ex_mem_i.debug.rs2_s;
            w_wb_next.debug.mem_addr = ex_mem_i.alu_res;
            w_wb_next.debug.rmask    = (w_access & ex_mem_i.is_load)  ? w_mask    : '0;
            w_wb_next.debug.wmask    = (w_access & ex_mem_i.is_store) ? w_mask    : '0;
            w_wb_next.debug.wdata    = (w_access & ex_mem_i.is_store) ? w_st_data : '0;
            w_wb_next.debug.rdata    = w_load_done ? dmem_rdata_i : '0;
            w_wb_next.debug.misalign = w_misalign;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mem_wb  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mem_wb  <= w_wb_next;
            r_timeout <= w_timeout;
            // Counter restarts on every entry into WAIT_RSP.
            if (r_state == ST_WAIT_RSP) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign mem_wb_o  = r_mem_wb;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage (RSP_TIMEOUT = 4).
// ---------------------------------------------------------------------------
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic             clk;
    logic             rst;
    ex_mem_t          ex;
    logic             stall;
    logic             req;
    logic             we;
    logic [ADDRW-1:0] addr;
    logic [MASKW-1:0] wmask;
    logic [XLEN-1:0]  wdata;
    logic             gnt;
    logic             rvalid;
    logic [XLEN-1:0]  rdata;
    mem_wb_t          wb;
    logic             tmo;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.RSP_TIMEOUT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ex_mem_i      (ex),
        .stall_o       (stall),
        .dmem_req_o    (req),
        .dmem_we_o     (we),
        .dmem_addr_o   (addr),
        .dmem_wmask_o  (wmask),
        .dmem_wdata_o  (wdata),
        .dmem_gnt_i    (gnt),
        .dmem_rvalid_i (rvalid),
        .dmem_rdata_i  (rdata),
        .mem_wb_o      (wb),
        .timeout_o     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic ld, input mem_size_e sz, input logic [31:0] a,
                           input logic [31:0] d, input logic uns);
        ex = '0;
        ex.valid       = 1'b1;
        ex.is_load     = ld;
        ex.is_store    = ~ld;
        ex.size        = sz;
        ex.alu_res     = a;
        ex.rs2_v       = d;
        ex.rd_s        = 5'd7;
        ex.rd_we       = ld;
        ex.unsigned_ld = uns;
    endtask

    initial begin
        rst = 1'b0; ex = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        step(); step();
        chk("rst_valid", 32'(wb.valid), 32'd0);
        chk("rst_req",   32'(req),      32'd0);
        chk("rst_stall", 32'(stall),    32'd0);
        chk("rst_tmo",   32'(tmo),      32'd0);
        rst = 1'b1;
        step();

        // ALU op
        ex = '0; ex.valid = 1'b1; ex.alu_res = 32'h1234; ex.rd_s = 5'd5; ex.rd_we = 1'b1;
        ex.debug.pc = 32'h8000_0010;
        #1;
        chk("alu_req",   32'(req),   32'd0);
        chk("alu_stall", 32'(stall), 32'd0);
        step();
        $display("txn alu rd_v=%h", wb.rd_v);
        chk("alu_valid", 32'(wb.valid), 32'd1);
        chk("alu_rd_v",  wb.rd_v,       32'h1234);
        chk("alu_rd_s",  32'(wb.rd_s),  32'd5);
        chk("alu_rd_we", 32'(wb.rd_we), 32'd1);
        chk("alu_pc",    wb.debug.pc,   32'h8000_0010);
        ex = '0;
        step();
        chk("idle_valid", 32'(wb.valid), 32'd0);

        // Store byte at 0x103, grant after 3 cycles
        set_mem(1'b0, MEM_B, 32'h103, 32'hAB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sb_req",   32'(req),   32'd1);
            chk("sb_we",    32'(we),    32'd1);
            chk("sb_addr",  addr,       32'h100);
            chk("sb_wmask", 32'(wmask), 32'h8);
            chk("sb_wdata", wdata,      32'hABAB_ABAB);
            chk("sb_stall", 32'(stall), 32'd1);
            step();
            chk("sb_nowb",  32'(wb.valid), 32'd0);
        end
        gnt = 1'b1;
        #1;
        chk("sb_gnt_stall", 32'(stall), 32'd0);
        step();
        gnt = 1'b0; ex = '0;
        $display("txn store_b wmask=%h", wb.debug.wmask);
        chk("sb_valid", 32'(wb.valid),       32'd1);
        chk("sb_rd_we", 32'(wb.rd_we),       32'd0);
        chk("sb_dbgwm", 32'(wb.debug.wmask), 32'h8);
        step();
        chk("sb_once", 32'(wb.valid), 32'd0);

        // Load half signed / unsigned at 0x102, rvalid 2 cycles after grant
        for (int u = 0; u < 2; u++) begin
            set_mem(1'b1, MEM_H, 32'h102, 32'h0, u[0]);
            gnt = 1'b1;
            #1;
            chk("lh_req",   32'(req),   32'd1);
            chk("lh_wmask", 32'(wmask), 32'd0);
            chk("lh_stall", 32'(stall), 32'd1);
            step();
            gnt = 1'b0;
            #1;
            chk("lh_wait_req",   32'(req),   32'd0);
            chk("lh_wait_stall", 32'(stall), 32'd1);
            step();
            rvalid = 1'b1; rdata = 32'h8001_0000;
            #1;
            chk("lh_rv_stall", 32'(stall), 32'd0);
            step();
            rvalid = 1'b0; ex = '0;
            $display("txn load_h unsigned=%0d rd_v=%h", u, wb.rd_v);
            chk("lh_valid", 32'(wb.valid), 32'd1);
            chk("lh_rd_v",  wb.rd_v, (u == 0) ? 32'hFFFF_8001 : 32'h0000_8001);
            chk("lh_rd_we", 32'(wb.rd_we), 32'd1);
            chk("lh_rdata", wb.debug.rdata, 32'h8001_0000);
            step();
        end

        // Load word, zero-wait
        set_mem(1'b1, MEM_W, 32'h200, 32'h0, 1'b0);
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_stall", 32'(stall), 32'd0);
        chk("lw_addr",  addr,       32'h200);
        step();
        gnt = 1'b0; rvalid = 1'b0; ex = '0;
        $display("txn load_w rd_v=%h", wb.rd_v);
        chk("lw_valid", 32'(wb.valid), 32'd1);
        chk("lw_rd_v",  wb.rd_v,       32'hDEAD_BEEF);
        step();

        // Store half at 0x102 and store word at 0x104, immediate grant
        set_mem(1'b0, MEM_H, 32'h102, 32'h1234_CDEF, 1'b0);
        gnt = 1'b1;
        #1;
        chk("sh_wmask", 32'(wmask), 32'hC);
        chk("sh_wdata", wdata,      32'hCDEF_CDEF);
        chk("sh_stall", 32'(stall), 32'd0);
        step();
        $display("txn store_h valid=%0d", wb.valid);
        chk("sh_valid", 32'(wb.valid), 32'd1);
        set_mem(1'b0, MEM_W, 32'h104, 32'h1234_CDEF, 1'b0);
        #1;
        chk("sw_wmask", 32'(wmask), 32'hF);
        chk("sw_wdata", wdata,      32'h1234_CDEF);
        chk("sw_addr",  addr,       32'h104);
        step();
        gnt = 1'b0; ex = '0;
        $display("txn store_w valid=%0d", wb.valid);
        chk("sw_valid", 32'(wb.valid), 32'd1);
        step();

        // Load byte signed at 0x101, zero-wait
        set_mem(1'b1, MEM_B, 32'h101, 32'h0, 1'b0);
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'h0000_80FF;
        step();
        gnt = 1'b0; rvalid = 1'b0; ex = '0;
        $display("txn load_b rd_v=%h", wb.rd_v);
        chk("lb_rd_v", wb.rd_v, 32'hFFFF_FF80);
        step();

        // Timeout: no rvalid, fires on the 4th WAIT cycle
        set_mem(1'b1, MEM_W, 32'h300, 32'h0, 1'b0);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_stall", 32'(stall), 32'd1);
            step();
            chk("to_tmo_early", 32'(tmo),      32'd0);
            chk("to_wb_early",  32'(wb.valid), 32'd0);
        end
        #1;
        chk("to_last_stall", 32'(stall), 32'd0);
        step();
        ex = '0;
        $display("txn timeout tmo=%0d valid=%0d rd_we=%0d", tmo, wb.valid, wb.rd_we);
        chk("to_tmo",   32'(tmo),      32'd1);
        chk("to_valid", 32'(wb.valid), 32'd1);
        chk("to_rd_we", 32'(wb.rd_we), 32'd0);
        step();
        chk("to_tmo_pulse", 32'(tmo),      32'd0);
        chk("to_once",      32'(wb.valid), 32'd0);

        // Reset in WAIT_RSP, then late rvalid ignored
        set_mem(1'b1, MEM_W, 32'h400, 32'h0, 1'b0);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("mr_valid", 32'(wb.valid), 32'd0);
        rst = 1'b1; ex = '0; rvalid = 1'b1; rdata = 32'h1111_2222;
        #1;
        chk("mr_stall", 32'(stall), 32'd0);
        chk("mr_req",   32'(req),   32'd0);
        step();
        rvalid = 1'b0;
        $display("txn reset_mid_wait valid=%0d", wb.valid);
        chk("mr_late_rv", 32'(wb.valid), 32'd0);
        step();

        // Misaligned word load at 0x102
        set_mem(1'b1, MEM_W, 32'h102, 32'h0, 1'b0);
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
`ifdef MEM_MISALIGN_CHECK_EN
        #1;
        chk("mis_req", 32'(req), 32'd0);
        step();
        $display("txn misalign misalign=%0d", wb.debug.misalign);
        chk("mis_valid", 32'(wb.valid),          32'd1);
        chk("mis_rd_we", 32'(wb.rd_we),          32'd0);
        chk("mis_flag",  32'(wb.debug.misalign), 32'd1);
`else
        #1;
        chk("mis_req", 32'(req), 32'd1);
        step();
        $display("txn misalign_unchecked rd_v=%h", wb.rd_v);
        chk("mis_rd_v", wb.rd_v,                32'h0000_DEAD);
        chk("mis_flag", 32'(wb.debug.misalign), 32'd0);
`endif
        gnt = 1'b0; rvalid = 1'b0; ex = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
